// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - serial-in/parallel-out word assembler with one-cycle completion pulse
module sipo_deserializer #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 bit_valid,
    input  logic                 bit_in,
    output logic [N-1:0]         word_out,
    output logic                 word_valid,
    output logic                 busy,
    output logic [$clog2(N)-1:0] bit_count
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state_q;
    logic [N-1:0]    sr_q;
    logic [N-1:0]    sr_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [N-1:0]    word_q;
    logic            valid_q;
    logic            busy_q;

    // Shift-register and counter values if the current bit is accepted
    always_comb begin
        sr_d  = MSB_FIRST ? {sr_q[N-2:0], bit_in} : {bit_in, sr_q[N-1:1]};
        cnt_d = cnt_q + CW'(1);
    end

    // Assembly FSM: rst over clear over bit_valid; completion loads word_q and pulses valid_q
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (clear) begin
                state_q <= IDLE;
                sr_q    <= '0;
                cnt_q   <= '0;
                busy_q  <= 1'b0;
            end else if (bit_valid) begin
                sr_q <= sr_d;
                if (state_q == IDLE) begin
                    // N >= 2, so the first bit of a word can never complete it
                    state_q <= SHIFT;
                    cnt_q   <= CW'(1);
                    busy_q  <= 1'b1;
                end else if (cnt_q == LAST_IDX) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    word_q  <= sr_d;
                    valid_q <= 1'b1;
                end else begin
                    cnt_q   <= cnt_d;
                    busy_q  <= 1'b1;
                end
            end
        end
    end

    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign busy       = busy_q;
    assign bit_count  = cnt_q;

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
Serial-in/parallel-out front stage that assembles an N-bit word from a bit stream qualified by bit_valid. On completion it presents the word on word_out and pulses word_valid for exactly one cycle. word_valid drives the enable of the downstream N-bit holding register, and word_out drives its data input. It sits directly upstream of that register in the datapath.

Parameters:
N, 8, word width in bits; legal range N >= 2
MSB_FIRST, 1, 1 = first accepted bit lands in word_out[N-1]; 0 = first accepted bit lands in word_out[0]

Ports:
clk  input  1  rising-edge clock, single clock domain
rst  input  1  synchronous, active-high reset
clear  input  1  synchronous abort of the partial word in progress
bit_valid  input  1  bit_in is accepted on this rising edge of clk
bit_in  input  1  serial data bit
word_out  output  N  last completed word; registered
word_valid  output  1  one-cycle pulse, high the cycle word_out is updated
busy  output  1  high while a partial word is held (bit_count != 0)
bit_count  output  $clog2(N)  number of bits accepted into the current partial word, 0..N-1

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All outputs are registered and there is no combinational input-to-output path.
- Reset values: word_out = 0, word_valid = 0, busy = 0, bit_count = 0, internal shift register = 0.
- Priority, highest first: rst, then clear, then bit_valid.
- FSM has two states:
  - IDLE (bit_count == 0).
  - SHIFT (0 < bit_count < N).
  - IDLE -> SHIFT on the first accepted bit.
  - SHIFT -> IDLE on the Nth accepted bit, or on clear.
- Accepting a bit (bit_valid=1, no rst or clear):
  - MSB_FIRST=1: shift register <= {sr[N-2:0], bit_in}.
  - MSB_FIRST=0: shift register <= {bit_in, sr[N-1:1]}.
  - bit_count increments.
- Completion, when bit_count == N-1 and bit_valid=1. On that edge:
  - word_out <= the full word including the current bit_in.
  - word_valid <= 1.
  - bit_count <= 0.
  - Latency: word_valid is high in the cycle immediately after the edge on which the Nth bit is accepted.
- word_valid is high for exactly one cycle per completed word and is low in every other cycle.
- word_out holds its value between completions. clear does not alter it.
- Gaps: bit_valid may deassert for any number of cycles. The partial word and bit_count hold with no timeout.
- Back-to-back: with bit_valid held high continuously, word_valid pulses once every N cycles. The first bit of the next word may be accepted on the same edge that completes the current word's output; no bubble is required.
- clear: bit_count <= 0, shift register <= 0, word_valid <= 0.
  - bit_in is discarded even if bit_valid=1 on that edge.
  - A word that would have completed on that edge is not emitted.
- rst mid-word: all state returns to reset values and the partial word is lost.
- bit_in is ignored when bit_valid=0. Values are don't-care, including X.
- busy equals (bit_count != 0) and is registered together with bit_count.
- Widths: bit_count wraps N-1 -> 0 only via completion. It never reaches N.

Test Plan:
- Reset, then MSB_FIRST=1, N=8, bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles -> word_out=0xA5 with a 1-cycle word_valid the cycle after the 8th bit; bit_count=0; busy=0.
- Same bit stream with MSB_FIRST=0 -> word_out=0xA5 as well, since the pattern is palindromic. Then bits 1,1,1,1,0,0,0,0 -> word_out=0x0F, and with MSB_FIRST=1 the same bits -> 0xF0.
- Continuous bit_valid for 16 cycles carrying 0x3C then 0xC3, MSB first -> word_valid pulses exactly twice, 8 cycles apart, with word_out=0x3C then 0xC3.
- 0xA5 sent with random bit_valid gaps of 0-5 cycles -> word_out=0xA5 and a single word_valid pulse; bit_count holds during each gap.
- 5 bits accepted, then clear asserted together with bit_valid=1 -> bit_count=0, busy=0, no word_valid, word_out keeps its prior value. Next 8 bits 0x5A -> word_out=0x5A.
- rst asserted after 3 bits of a word -> all outputs 0 on the next cycle. The following 8 bits 0xFF -> word_out=0xFF with a single word_valid pulse.
